sram_arbiter: RTL and testbench

//  Shares a single sram_driver between two requesters: port 0 (CPU) and port 1 (video/DMA).

---
 rtl/sram_arb_pkg.sv | 27 ++
 rtl/sram_arb_select.sv | 41 ++++
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
//
// Contents:
//   arb_state_e  FSM encoding: IDLE, ISSUE, ACCEPT, BUSY
//   NUM_PORTS    number of requesters (2)
//   PORT_CPU     port index of the CPU requester (0)
//   PORT_DMA     port index of the video/DMA requester (1)
//   port_onehot  port index -> one-hot done vector

package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACCEPT = 2'd2,
    BUSY   = 2'd3
  } arb_state_e;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    return (port == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_arb_select.sv
// rtl/sram_arb_select.sv - combinational winner picker for the SRAM arbiter
//
// Build option: SRAM_ARB_ROUND_ROBIN_EN
//   defined   - on a tie the port that did not win last time is picked
//   undefined - fixed priority, PORT_CPU wins every tie
//
// Ports:
//   req_i        in  NUM_PORTS  pending requests
//   last_grant_i in  1          port that completed the previous transaction
//   grant_o      out 1          chosen port index
//   valid_o      out 1          at least one request is pending

import sram_arb_pkg::*;

module sram_arb_select (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 last_grant_i,
  output logic                 grant_o,
  output logic                 valid_o
);

`ifndef SRAM_ARB_ROUND_ROBIN_EN
  // History is still tracked by the top; fixed priority simply ignores it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    valid_o = |req_i;
    grant_o = PORT_CPU;
    if (req_i[PORT_DMA] && !req_i[PORT_CPU]) begin
      grant_o = PORT_DMA;
    end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    else if (req_i[PORT_DMA] && req_i[PORT_CPU]) begin
      grant_o = ~last_grant_i;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one sram_driver between a CPU port and a video/DMA port
//
// Build option: SRAM_ARB_ROUND_ROBIN_EN (tie-break policy, handled in sram_arb_select)
//
// Parameters:
//   ADDR_W  address width of the driver bus (13)
//   DATA_W  data width of the driver buses (8)
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req[1:0], we[1:0]    per-port request and write flag (held until done)
//   addr0/addr1          per-port address
//   wdata0/wdata1        per-port write data
//   done[1:0]            one-cycle completion pulse for the served port
//   rdata                read data, valid while done pulses for a read
//   mem_start/mem_re     driver start strobe and read select
//   mem_address          driver address
//   mem_data_write       driver write data
//   mem_ready            driver idle/complete indication
//   mem_data_read        driver read data

import sram_arb_pkg::*;

module sram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_start,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data_read
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_start_q, mem_start_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_write_q, mem_data_write_d;

  logic sel_grant;
  logic sel_valid;

  sram_arb_select u_select (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (sel_grant),
    .valid_o      (sel_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      grant_q          <= PORT_CPU;
      last_grant_q     <= PORT_DMA;
      done_q           <= '0;
      rdata_q          <= '0;
      mem_start_q      <= 1'b0;
      mem_re_q         <= 1'b0;
      mem_address_q    <= '0;
      mem_data_write_q <= '0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      last_grant_q     <= last_grant_d;
      done_q           <= done_d;
      rdata_q          <= rdata_d;
      mem_start_q      <= mem_start_d;
      mem_re_q         <= mem_re_d;
      mem_address_q    <= mem_address_d;
      mem_data_write_q <= mem_data_write_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    done_d           = '0;
    rdata_d          = rdata_q;
    mem_start_d      = 1'b0;
    mem_re_d         = mem_re_q;
    mem_address_d    = mem_address_q;
    mem_data_write_d = mem_data_write_q;

    unique case (state_q)
      IDLE: begin
        // The cycle right after done is skipped so the finished requester
        // has time to drop req before it could be granted again.
        if (mem_ready && sel_valid && (done_q == 2'b00)) begin
          grant_d          = sel_grant;
          mem_re_d         = ~we[sel_grant];
          mem_address_d    = (sel_grant == PORT_DMA) ? addr1 : addr0;
          mem_data_write_d = (sel_grant == PORT_DMA) ? wdata1 : wdata0;
          mem_start_d      = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        state_d = ACCEPT;
      end
      ACCEPT: begin
        // ready falling means the driver has latched the job.
        if (!mem_ready) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (mem_re_q) begin
            rdata_d = mem_data_read;
          end
          done_d       = port_onehot(grant_q);
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done           = done_q;
  assign rdata          = rdata_q;
  assign mem_start      = mem_start_q;
  assign mem_re         = mem_re_q;
  assign mem_address    = mem_address_q;
  assign mem_data_write = mem_data_write_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural driver and SRAM

module tb_sram_arbiter;

  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 8;
  localparam int WAIT_TIME   = 2;
  localparam int INIT_CYCLES = 3;
  localparam int BUDGET      = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] a0 = '0, a1 = '0;
  logic [DATA_W-1:0] d0 = '0, d1 = '0;

  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              mem_start, mem_re;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_write;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data_read;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            ({req1, req0}),
    .we             ({we1, we0}),
    .addr0          (a0),
    .addr1          (a1),
    .wdata0         (d0),
    .wdata1         (d1),
    .done           (done),
    .rdata          (rdata),
    .mem_start      (mem_start),
    .mem_re         (mem_re),
    .mem_address    (mem_address),
    .mem_data_write (mem_data_write),
    .mem_ready      (mem_ready),
    .mem_data_read  (mem_data_read)
  );

  // Behavioural sram_driver + SRAM
  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  logic              drv_ready_q = 1'b0;
  logic              drv_busy_q = 1'b0;
  logic              hold_ready = 1'b0;
  int                drv_init_q = INIT_CYCLES;
  int                drv_cnt_q = 0;
  logic [ADDR_W-1:0] drv_addr_q = '0;
  logic              drv_re_q = 1'b0;
  logic [DATA_W-1:0] drv_wdata_q = '0;
  logic [DATA_W-1:0] drv_rdata_q = '0;

  assign mem_ready     = drv_ready_q && !hold_ready;
  assign mem_data_read = drv_rdata_q;

  always @(posedge clk) begin
    if (reset) begin
      drv_ready_q <= 1'b0;
      drv_busy_q  <= 1'b0;
      drv_init_q  <= INIT_CYCLES;
      drv_cnt_q   <= 0;
      drv_rdata_q <= '0;
    end else if (drv_init_q != 0) begin
      drv_init_q <= drv_init_q - 1;
      if (drv_init_q == 1) drv_ready_q <= 1'b1;
    end else if (mem_ready && mem_start) begin
      drv_ready_q <= 1'b0;
      drv_busy_q  <= 1'b1;
      drv_cnt_q   <= WAIT_TIME;
      drv_addr_q  <= mem_address;
      drv_re_q    <= mem_re;
      drv_wdata_q <= mem_data_write;
    end else if (drv_busy_q) begin
      if (drv_cnt_q == 0) begin
        if (drv_re_q) drv_rdata_q <= sram[drv_addr_q];
        else          sram[drv_addr_q] <= drv_wdata_q;
        drv_ready_q <= 1'b1;
        drv_busy_q  <= 1'b0;
      end else begin
        drv_cnt_q <= drv_cnt_q - 1;
      end
    end
  end

  // Scoreboard
  typedef struct { logic [ADDR_W-1:0] addr; logic re; logic [DATA_W-1:0] wdata; } start_t;
  typedef struct { logic port; logic re; logic [DATA_W-1:0] rdata; } done_t;
  start_t start_exp[$];
  done_t  done_exp[$];
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [DATA_W-1:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rd);
    start_t s;
    done_t  e;
    s.addr = a; s.re = ~w; s.wdata = d;
    e.port = p; e.re = ~w; e.rdata = rd;
    start_exp.push_back(s);
    done_exp.push_back(e);
  endtask

  start_t ms;
  done_t  md;
  always @(negedge clk) begin
    if (reset) begin
      model_rdata = '0;
    end else begin
      if (mem_start) begin
        start_cnt++;
        if (start_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got mem_start=1 at addr 0x%0h required none", mem_address);
        end else begin
          ms = start_exp.pop_front();
          check("start_addr", 32'(mem_address), 32'(ms.addr));
          check("start_re", 32'(mem_re), 32'(ms.re));
          if (!ms.re) check("start_wdata", 32'(mem_data_write), 32'(ms.wdata));
        end
      end
      if (done != 2'b00) begin
        if (done_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=%b required 00", done);
        end else begin
          md = done_exp.pop_front();
          check("done_port", 32'(done), (md.port ? 32'd2 : 32'd1));
          if (md.re) model_rdata = md.rdata;
          check("rdata", 32'(rdata), 32'(model_rdata));
        end
      end
    end
  end

  task automatic set_port(input logic p, input logic r, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 1'b0) begin req0 = r; we0 = w; a0 = a; d0 = d; end
    else           begin req1 = r; we1 = w; a1 = a; d1 = d; end
  endtask

  task automatic wait_done(input logic p);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (done[p]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout_done: port %0d got no done, required one within %0d cycles", p, BUDGET);
    end
  endtask

  task automatic transact(input logic p, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    @(negedge clk);
    set_port(p, 1'b1, w, a, d);
    wait_done(p);
    set_port(p, 1'b0, w, a, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_mem_start"}, 32'(mem_start), 32'd0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    check({tag, "_mem_data_write"}, 32'(mem_data_write), 32'd0);
  endtask

  logic [ADDR_W-1:0] burst_addr [3];
  logic [DATA_W-1:0] burst_data [3];
  int sc;
  logic seen;

  initial begin
    burst_addr[0] = 13'h1FFF; burst_data[0] = 8'h3C;
    burst_addr[1] = 13'h0000; burst_data[1] = 8'h5A;
    burst_addr[2] = 13'h0001; burst_data[2] = 8'hC3;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // 1: single write from port 0
    sc = start_cnt;
    push(1'b0, 1'b1, 13'h0010, 8'hA5, 8'h00);
    transact(1'b0, 1'b1, 13'h0010, 8'hA5);
    check("t1_start_count", 32'(start_cnt - sc), 32'd1);
    check("t1_sram", 32'(sram[13'h0010]), 32'hA5);

    // preload through port 0
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b1, burst_addr[i], burst_data[i], 8'h00);
      transact(1'b0, 1'b1, burst_addr[i], burst_data[i]);
    end

    // 2: single read from port 1 (leaves last_grant = 1)
    push(1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5);
    transact(1'b1, 1'b0, 13'h0010, 8'h00);

    // 3: tie, both ports issue two reads each
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b0, 13'h0010, 8'h00, 8'hA5);
    push(1'b1, 1'b0, 13'h0000, 8'h00, 8'h5A);
    push(1'b0, 1'b0, 13'h1FFF, 8'h00, 8'h3C);
    push(1'b1, 1'b0, 13'h0001, 8'h00, 8'hC3);
`else
    push(1'b0, 1'b0, 13'h0010, 8'h00, 8'hA5);
    push(1'b0, 1'b0, 13'h1FFF, 8'h00, 8'h3C);
    push(1'b1, 1'b0, 13'h0000, 8'h00, 8'h5A);
    push(1'b1, 1'b0, 13'h0001, 8'h00, 8'hC3);
`endif
    fork
      begin
        transact(1'b0, 1'b0, 13'h0010, 8'h00);
        transact(1'b0, 1'b0, 13'h1FFF, 8'h00);
      end
      begin
        transact(1'b1, 1'b0, 13'h0000, 8'h00);
        transact(1'b1, 1'b0, 13'h0001, 8'h00);
      end
    join

    // 4: back-to-back, port 0 keeps req high and changes address after each done
    sc = start_cnt;
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, burst_addr[i], 8'h00, burst_data[i]);
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, burst_addr[0], 8'h00);
    for (int i = 0; i < 3; i++) begin
      wait_done(1'b0);
      if (i < 2) set_port(1'b0, 1'b1, 1'b0, burst_addr[i+1], 8'h00);
    end
    set_port(1'b0, 1'b0, 1'b0, 13'h0000, 8'h00);
    check("t4_start_count", 32'(start_cnt - sc), 32'd3);

    // 5: reset while the arbiter waits in BUSY
    start_exp.push_back('{addr: 13'h0020, re: 1'b0, wdata: 8'h77});
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 13'h0020, 8'h77);
    seen = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (!mem_ready && !mem_start) begin seen = 1'b1; break; end
    end
    check("t5_driver_took_job", 32'(seen), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 13'h0000, 8'h00);
    @(negedge clk);
    check_reset_outputs("t5");
    reset = 1'b0;
    push(1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5);
    transact(1'b1, 1'b0, 13'h0010, 8'h00);

    // 6: request while the driver is not yet ready after reset
    @(negedge clk);
    reset = 1'b1;
    hold_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sc = start_cnt;
    push(1'b0, 1'b0, 13'h0001, 8'h00, 8'hC3);
    set_port(1'b0, 1'b1, 1'b0, 13'h0001, 8'h00);
    repeat (15) @(negedge clk);
    check("t6_no_start_while_not_ready", 32'(start_cnt - sc), 32'd0);
    hold_ready = 1'b0;
    wait_done(1'b0);
    set_port(1'b0, 1'b0, 1'b0, 13'h0000, 8'h00);
    check("t6_start_count", 32'(start_cnt - sc), 32'd1);

    repeat (10) @(negedge clk);
    check("pending_starts", 32'(start_exp.size()), 32'd0);
    check("pending_dones", 32'(done_exp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
